// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the conv datapath window sequencer.
package conv_pkg;

  localparam int PIX_W = 8;
  localparam int COLS  = 12;
  localparam int SEL_W = 4;
  localparam int ROW_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SCAN  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/win_scan_ctrl.sv
// Window scan sequencer: requests three source lines per row, then steps the
// window select across all columns under a valid/ready handshake to the MAC.
module win_scan_ctrl
  import conv_pkg::*;
(
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] rows,
  output logic             busy,
  output logic             done,
  output logic             line_req,
  output logic [ROW_W-1:0] line_row,
  input  logic             line_ack,
  output logic [SEL_W-1:0] win_sel,
  output logic             win_zero,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [ROW_W-1:0] win_row,
  output logic             win_last
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(COLS - 1);

  state_t           state_r, state_s;
  logic [ROW_W-1:0] row_r, row_s;
  logic [ROW_W-1:0] rows_r, rows_s;
  logic             busy_s, done_s, line_req_s, win_zero_s, win_valid_s, win_last_s;
  logic [ROW_W-1:0] line_row_s, win_row_s;
  logic [SEL_W-1:0] win_sel_s, sel_inc_s;
  logic             last_row_s;

  assign last_row_s = (row_r == (rows_r - {{(ROW_W-1){1'b0}}, 1'b1}));
  assign sel_inc_s  = win_sel + {{(SEL_W-1){1'b0}}, 1'b1};

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_s     = state_r;
    row_s       = row_r;
    rows_s      = rows_r;
    busy_s      = busy;
    done_s      = 1'b0;
    line_req_s  = line_req;
    line_row_s  = line_row;
    win_sel_s   = win_sel;
    win_zero_s  = win_zero;
    win_valid_s = win_valid;
    win_row_s   = win_row;
    win_last_s  = win_last;
    if (abort) begin
      state_s     = S_IDLE;
      row_s       = {ROW_W{1'b0}};
      rows_s      = {ROW_W{1'b0}};
      busy_s      = 1'b0;
      line_req_s  = 1'b0;
      line_row_s  = {ROW_W{1'b0}};
      win_sel_s   = {SEL_W{1'b0}};
      win_zero_s  = 1'b0;
      win_valid_s = 1'b0;
      win_row_s   = {ROW_W{1'b0}};
      win_last_s  = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && (rows != {ROW_W{1'b0}})) begin
            state_s    = S_FETCH;
            rows_s     = rows;
            row_s      = {ROW_W{1'b0}};
            busy_s     = 1'b1;
            line_req_s = 1'b1;
            line_row_s = {ROW_W{1'b0}};
          end else if (start) begin
            state_s = S_FIN;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_FETCH: begin
          if (line_ack) begin
            state_s     = S_SCAN;
            line_req_s  = 1'b0;
            win_sel_s   = {SEL_W{1'b0}};
            win_valid_s = 1'b1;
            win_row_s   = row_r;
            win_zero_s  = last_row_s;
            win_last_s  = last_row_s && (SEL_MAX == {SEL_W{1'b0}});
          end else begin
            state_s = S_FETCH;
          end
        end
        S_SCAN: begin
          if (win_valid && win_ready && (win_sel != SEL_MAX)) begin
            win_sel_s  = sel_inc_s;
            win_last_s = last_row_s && (sel_inc_s == SEL_MAX);
          end else if (win_valid && win_ready) begin
            // Row finished: either fetch the next three lines or close the frame.
            win_valid_s = 1'b0;
            win_last_s  = 1'b0;
            win_zero_s  = 1'b0;
            if (last_row_s) begin
              state_s = S_FIN;
              done_s  = 1'b1;
              busy_s  = 1'b0;
            end else begin
              state_s    = S_FETCH;
              row_s      = row_r + {{(ROW_W-1){1'b0}}, 1'b1};
              line_req_s = 1'b1;
              line_row_s = row_r + {{(ROW_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_s = S_SCAN;
          end
        end
        S_FIN: begin
          state_s = S_IDLE;
          busy_s  = 1'b0;
        end
        default: begin
          state_s     = S_IDLE;
          busy_s      = 1'b0;
          line_req_s  = 1'b0;
          win_valid_s = 1'b0;
          win_last_s  = 1'b0;
          win_zero_s  = 1'b0;
        end
      endcase
    end
  end

  // FSM state and frame counters.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= S_IDLE;
      row_r   <= {ROW_W{1'b0}};
      rows_r  <= {ROW_W{1'b0}};
    end else begin
      state_r <= state_s;
      row_r   <= row_s;
      rows_r  <= rows_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      line_req  <= 1'b0;
      line_row  <= {ROW_W{1'b0}};
      win_sel   <= {SEL_W{1'b0}};
      win_zero  <= 1'b0;
      win_valid <= 1'b0;
      win_row   <= {ROW_W{1'b0}};
      win_last  <= 1'b0;
    end else begin
      busy      <= busy_s;
      done      <= done_s;
      line_req  <= line_req_s;
      line_row  <= line_row_s;
      win_sel   <= win_sel_s;
      win_zero  <= win_zero_s;
      win_valid <= win_valid_s;
      win_row   <= win_row_s;
      win_last  <= win_last_s;
    end
  end

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Directed bench for win_scan_ctrl: full frames, back-pressure, empty frame,
// abort, ignored inputs and asynchronous reset mid-scan.
module tb_win_scan_ctrl;
  import conv_pkg::*;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [ROW_W-1:0] rows_i = 8'd0;
  logic             busy, done, line_req, line_ack, win_zero, win_valid, win_ready, win_last;
  logic [ROW_W-1:0] line_row, win_row;
  logic [SEL_W-1:0] win_sel;
  int               checks = 0;
  int               errors = 0;

  win_scan_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort), .rows(rows_i),
    .busy(busy), .done(done), .line_req(line_req), .line_row(line_row),
    .line_ack(line_ack), .win_sel(win_sel), .win_zero(win_zero),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
    .win_last(win_last)
  );

  always #5 HCLK = ~HCLK;

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_line_req"}, 32'(line_req), 32'd0);
    chk({tag, "_line_row"}, 32'(line_row), 32'd0);
    chk({tag, "_win_sel"}, 32'(win_sel), 32'd0);
    chk({tag, "_win_zero"}, 32'(win_zero), 32'd0);
    chk({tag, "_win_valid"}, 32'(win_valid), 32'd0);
    chk({tag, "_win_row"}, 32'(win_row), 32'd0);
    chk({tag, "_win_last"}, 32'(win_last), 32'd0);
  endtask

  // One frame with win_ready=1 and line_ack two cycles after line_req rises.
  // inj_row: row where a stray start/line_ack/rows change is injected at sel 3.
  // ab_row/ab_sel: position of an abort (-1 = none).
  task automatic run_frame(input int nrows, input int inj_row, input int ab_row, input int ab_sel);
    rows_i = 8'(nrows);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    for (int r = 0; r < nrows; r++) begin
      chk("fetch_req", 32'(line_req), 32'd1);
      chk("fetch_row", 32'(line_row), 32'(r));
      chk("fetch_valid", 32'(win_valid), 32'd0);
      cyc();
      chk("fetch_req_held", 32'(line_req), 32'd1);
      line_ack = 1'b1;
      cyc();
      line_ack = 1'b0;
      chk("ack_req_drop", 32'(line_req), 32'd0);
      for (int c = 0; c < COLS; c++) begin
        chk("scan_valid", 32'(win_valid), 32'd1);
        chk("scan_sel", 32'(win_sel), 32'(c));
        chk("scan_row", 32'(win_row), 32'(r));
        chk("scan_zero", 32'(win_zero), 32'(r == nrows - 1));
        chk("scan_last", 32'(win_last), 32'((r == nrows - 1) && (c == COLS - 1)));
        chk("scan_busy", 32'(busy), 32'd1);
        chk("scan_done", 32'(done), 32'd0);
        if (r == ab_row && c == ab_sel) begin
          abort = 1'b1;
          cyc();
          abort = 1'b0;
          chk_idle("abort");
          for (int k = 0; k < 3; k++) begin
            cyc();
            chk_idle("post_abort");
          end
          return;
        end
        if (r == inj_row && c == 3) begin
          start = 1'b1;
          line_ack = 1'b1;
          rows_i = 8'd7;
        end
        cyc();
        start = 1'b0;
        line_ack = 1'b0;
        rows_i = 8'(nrows);
      end
      if (r < nrows - 1) chk("row_end_valid", 32'(win_valid), 32'd0);
    end
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_busy", 32'(busy), 32'd0);
    chk("fin_valid", 32'(win_valid), 32'd0);
    chk("fin_req", 32'(line_req), 32'd0);
    cyc();
    chk("after_fin_done", 32'(done), 32'd0);
    chk("after_fin_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    line_ack = 1'b0;
    win_ready = 1'b1;
    #12;
    chk_idle("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;
    cyc();
    chk_idle("idle");

    // 3-row frame with stray start/line_ack/rows change during row 1 scan
    run_frame(3, 1, -1, -1);

    // 1-row frame with win_ready toggling every cycle
    rows_i = 8'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("bp_req", 32'(line_req), 32'd1);
    line_ack = 1'b1;
    cyc();
    line_ack = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      chk("bp_valid", 32'(win_valid), 32'd1);
      chk("bp_sel", 32'(win_sel), 32'(c));
      chk("bp_zero", 32'(win_zero), 32'd1);
      chk("bp_last", 32'(win_last), 32'(c == COLS - 1));
      win_ready = 1'b0;
      cyc();
      chk("bp_hold_valid", 32'(win_valid), 32'd1);
      chk("bp_hold_sel", 32'(win_sel), 32'(c));
      chk("bp_hold_zero", 32'(win_zero), 32'd1);
      chk("bp_hold_last", 32'(win_last), 32'(c == COLS - 1));
      chk("bp_hold_done", 32'(done), 32'd0);
      win_ready = 1'b1;
      cyc();
    end
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_valid_end", 32'(win_valid), 32'd0);
    cyc();
    chk("bp_done_end", 32'(done), 32'd0);

    // empty frame
    rows_i = 8'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_req", 32'(line_req), 32'd0);
    chk("empty_valid", 32'(win_valid), 32'd0);
    cyc();
    chk("empty_done_end", 32'(done), 32'd0);
    chk("empty_busy_end", 32'(busy), 32'd0);

    // abort in IDLE is a no-op, abort beats start
    abort = 1'b1;
    start = 1'b1;
    rows_i = 8'd2;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    chk_idle("abort_start");

    // abort at sel 5 of row 1, then a full 4-row frame
    run_frame(4, -1, 1, 5);
    run_frame(4, -1, -1, -1);

    // asynchronous reset mid-scan
    rows_i = 8'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    line_ack = 1'b1;
    cyc();
    line_ack = 1'b0;
    cyc();
    cyc();
    chk("pre_rst_sel", 32'(win_sel), 32'd2);
    chk("pre_rst_valid", 32'(win_valid), 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    cyc();
    chk_idle("post_rst");
    cyc();
    chk_idle("post_rst_idle");
    run_frame(1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
